// File: rtl/bp_pkg.sv
// Shared types and constants for the BP-mode block sequencer and its bits-required datapath.
package bp_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EVAL    = 2'd1,
    OUT     = 2'd2
  } bp_state_e;

  localparam int         BLK_LEN   = 4;
  localparam logic [1:0] ECGIDX_TC = 2'd3;
  localparam int         BITS_W    = 4;

endpackage

// File: rtl/Bits_required.sv
// Bits needed to code a 4-sample block: magnitude bits in SM form, full
// two's-complement width in TC form (zero slots are neutral in both).
module Bits_required
  import bp_pkg::*;
#(
  parameter int J = 10
) (
  input  logic signed [J-1:0]      s1,
  input  logic signed [J-1:0]      s2,
  input  logic signed [J-1:0]      s3,
  input  logic signed [J-1:0]      s4,
  input  logic [1:0]               ecgidx,
  output logic [BITS_W-1:0]        bits
);

  localparam logic [J-1:0]      J_ONE    = {{(J-1){1'b0}}, 1'b1};
  localparam logic [BITS_W-1:0] BITS_ONE = {{(BITS_W-1){1'b0}}, 1'b1};

  function automatic logic [J-1:0] magnitude(input logic [J-1:0] x);
    return x[J-1] ? ((~x) + J_ONE) : x;
  endfunction

  // Bit k set when bit k matches the bit above it, i.e. it is a redundant sign bit.
  function automatic logic [J-1:0] tc_mask(input logic [J-1:0] x);
    return ~(x ^ {x[J-1], x[J-1:1]});
  endfunction

  function automatic logic [BITS_W-1:0] top_bit_count(input logic [J-1:0] v);
    logic [BITS_W-1:0] n;
    n = '0;
    for (int i = 0; i < J; i++) begin
      n = v[i] ? BITS_W'(i + 1) : n;
    end
    return n;
  endfunction

  logic [J-1:0]      sm_or_s;
  logic [J-1:0]      tc_and_s;
  logic [J-1:0]      tc_diff_s;
  logic [BITS_W-1:0] sm_bits_s;
  logic [BITS_W-1:0] tc_bits_s;

  // Width evaluation for both coding forms, then mode select.
  always_comb begin
    sm_or_s   = magnitude(s1) | magnitude(s2) | magnitude(s3) | magnitude(s4);
    tc_and_s  = tc_mask(s1) & tc_mask(s2) & tc_mask(s3) & tc_mask(s4);
    tc_diff_s = ~tc_and_s;
    sm_bits_s = top_bit_count(sm_or_s);
    if (tc_diff_s == '0) begin
      tc_bits_s = BITS_ONE;
    end else begin
      tc_bits_s = top_bit_count(tc_diff_s) + BITS_ONE;
    end
    if (ecgidx == ECGIDX_TC) begin
      bits = tc_bits_s;
    end else begin
      bits = sm_bits_s;
    end
  end

endmodule

// File: rtl/bp_block_sequencer.sv
// Groups a valid/ready sample stream into 4-sample blocks, evaluates their bit
// width once per block and hands each block descriptor to the packer.
module bp_block_sequencer
  import bp_pkg::*;
#(
  parameter int J            = 10,
  parameter int FRAME_BLOCKS = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [J-1:0]             in_sample,
  input  logic [1:0]                      ecgidx,
  input  logic                            flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [J-1:0]             out_s1,
  output logic signed [J-1:0]             out_s2,
  output logic signed [J-1:0]             out_s3,
  output logic signed [J-1:0]             out_s4,
  output logic [BITS_W-1:0]               out_bits,
  output logic                            out_tc,
  output logic [2:0]                      out_nvalid,
  output logic                            out_last,
  output logic [$clog2(FRAME_BLOCKS)-1:0] out_blk_idx
);

  localparam int             IDX_W    = $clog2(FRAME_BLOCKS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BLOCKS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [2:0]     CNT_FULL = 3'(BLK_LEN);

  bp_state_e               state_r;
  bp_state_e               state_n_s;
  logic [2:0]              cnt_r;
  logic [2:0]              cnt_nxt_s;
  logic signed [J-1:0]     slot_r [BLK_LEN];
  logic [1:0]              mode_r;
  logic                    frame_end_r;
  logic [IDX_W-1:0]        blk_idx_r;
  logic                    in_ready_r;
  logic                    out_valid_r;
  logic [BITS_W-1:0]       out_bits_r;
  logic                    out_tc_r;
  logic [2:0]              out_nvalid_r;
  logic                    out_last_r;
  logic                    accept_s;
  logic                    flush_close_s;
  logic                    hs_s;
  logic [BITS_W-1:0]       bits_s;

  Bits_required #(.J(J)) u_bits_required (
    .s1     (slot_r[0]),
    .s2     (slot_r[1]),
    .s3     (slot_r[2]),
    .s4     (slot_r[3]),
    .ecgidx (mode_r),
    .bits   (bits_s)
  );

  // Next-state decode; a flush closes the block only if it holds at least one sample.
  always_comb begin
    state_n_s     = state_r;
    cnt_nxt_s     = cnt_r;
    accept_s      = 1'b0;
    flush_close_s = 1'b0;
    hs_s          = 1'b0;
    case (state_r)
      COLLECT: begin
        accept_s = in_valid;
        if (in_valid) begin
          cnt_nxt_s = cnt_r + 3'd1;
        end else begin
          cnt_nxt_s = cnt_r;
        end
        flush_close_s = flush && (cnt_nxt_s != 3'd0);
        if ((cnt_nxt_s == CNT_FULL) || flush_close_s) begin
          state_n_s = EVAL;
        end else begin
          state_n_s = COLLECT;
        end
      end
      EVAL: begin
        state_n_s = OUT;
      end
      OUT: begin
        hs_s = out_ready;
        if (out_ready) begin
          state_n_s = COLLECT;
        end else begin
          state_n_s = OUT;
        end
      end
      default: begin
        state_n_s = COLLECT;
      end
    endcase
  end

  // FSM, fill counter, block mode, frame position and registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= COLLECT;
      cnt_r       <= 3'd0;
      mode_r      <= 2'd0;
      frame_end_r <= 1'b0;
      blk_idx_r   <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      in_ready_r  <= (state_n_s == COLLECT);
      out_valid_r <= (state_n_s == OUT);
      if (accept_s && (cnt_r == 3'd0)) begin
        mode_r <= ecgidx;
      end
      if (hs_s) begin
        cnt_r       <= 3'd0;
        frame_end_r <= 1'b0;
        blk_idx_r   <= out_last_r ? '0 : (blk_idx_r + IDX_ONE);
      end else begin
        cnt_r <= cnt_nxt_s;
        if (flush_close_s) begin
          frame_end_r <= 1'b1;
        end
      end
    end
  end

  // Slot capture with zero padding on flush, and the descriptor registers loaded in EVAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BLK_LEN; i++) begin
        slot_r[i] <= '0;
      end
      out_bits_r   <= '0;
      out_tc_r     <= 1'b0;
      out_nvalid_r <= 3'd0;
      out_last_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        slot_r[cnt_r[1:0]] <= in_sample;
      end
      if (flush_close_s) begin
        for (int i = 0; i < BLK_LEN; i++) begin
          if (i >= int'(cnt_nxt_s)) begin
            slot_r[i] <= '0;
          end
        end
      end
      if ((state_r == COLLECT) && (state_n_s == EVAL)) begin
        out_nvalid_r <= cnt_nxt_s;
      end
      if (state_r == EVAL) begin
        out_bits_r <= bits_s;
        out_tc_r   <= (mode_r == ECGIDX_TC);
        out_last_r <= frame_end_r || (blk_idx_r == IDX_LAST);
      end
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_s1      = slot_r[0];
  assign out_s2      = slot_r[1];
  assign out_s3      = slot_r[2];
  assign out_s4      = slot_r[3];
  assign out_bits    = out_bits_r;
  assign out_tc      = out_tc_r;
  assign out_nvalid  = out_nvalid_r;
  assign out_last    = out_last_r;
  assign out_blk_idx = blk_idx_r;

endmodule

// File: tb/tb_bp_block_sequencer.sv
// Scoreboard bench: a block-level reference model predicts descriptors, a monitor checks them.
module tb_bp_block_sequencer;

  localparam int J  = 10;
  localparam int FB = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic signed [J-1:0]    in_sample;
  logic [1:0]             ecgidx;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [J-1:0]    out_s1, out_s2, out_s3, out_s4;
  logic [3:0]             out_bits;
  logic                   out_tc;
  logic [2:0]             out_nvalid;
  logic                   out_last;
  logic [3:0]             out_blk_idx;

  bp_block_sequencer #(.J(J), .FRAME_BLOCKS(FB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sample(in_sample), .ecgidx(ecgidx), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s1(out_s1), .out_s2(out_s2), .out_s3(out_s3), .out_s4(out_s4),
    .out_bits(out_bits), .out_tc(out_tc), .out_nvalid(out_nvalid),
    .out_last(out_last), .out_blk_idx(out_blk_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s1, s2, s3, s4;
    int bits, tc, nvalid, last, idx;
    longint rise;
  } desc_t;

  desc_t  exp_q[$];
  int     cur_q[$];
  int     cur_mode;
  int     m_idx;
  longint blk_start_q[$];
  longint cyc = 0;
  int     n_checks = 0;
  int     n_err = 0;
  int     stall_left = 0;
  bit     rand_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int sm_w(input int x);
    int m, w;
    m = (x < 0) ? -x : x;
    w = 0;
    while (m > 0) begin
      w++;
      m = m >> 1;
    end
    return w;
  endfunction

  function automatic int tc_w(input int x);
    int w;
    w = 1;
    while (x < -(1 << (w - 1)) || x >= (1 << (w - 1))) w++;
    return w;
  endfunction

  task automatic emit(input bit flushed, input longint acc_edge);
    desc_t d;
    int    s[4];
    d.nvalid = cur_q.size();
    for (int i = 0; i < 4; i++) s[i] = (i < cur_q.size()) ? cur_q[i] : 0;
    d.s1 = s[0]; d.s2 = s[1]; d.s3 = s[2]; d.s4 = s[3];
    d.tc = (cur_mode == 3) ? 1 : 0;
    d.bits = 0;
    for (int i = 0; i < 4; i++) begin
      int w;
      w = d.tc ? tc_w(s[i]) : sm_w(s[i]);
      if (w > d.bits) d.bits = w;
    end
    d.last = (flushed || m_idx == FB - 1) ? 1 : 0;
    d.idx  = m_idx;
    d.rise = acc_edge + 1;
    exp_q.push_back(d);
    m_idx = d.last ? 0 : m_idx + 1;
    cur_q.delete();
  endtask

  // Called #1 after a rising edge; returns whether the sample is taken at the next edge.
  task automatic drive(input bit v, input int s, input int e, input bit f, output bit acc);
    longint edge_n;
    bit     f_eff;
    in_valid  = v;
    in_sample = s[J-1:0];
    ecgidx    = e[1:0];
    flush     = f;
    acc    = v && in_ready;
    f_eff  = f && in_ready;
    edge_n = cyc + 1;
    if (acc) begin
      if (cur_q.size() == 0) begin
        cur_mode = e;
        blk_start_q.push_back(edge_n);
      end
      cur_q.push_back(s);
      if (cur_q.size() == 4) emit(f_eff, edge_n);
    end
    if (f_eff && cur_q.size() > 0) emit(1'b1, edge_n);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic send(input int s, input int e, input bit f);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 64) begin
      drive(1'b1, s, e, f, acc);
      tries++;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n, input bit f);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, f, acc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    cur_q.delete();
    exp_q.delete();
    m_idx = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bits", out_bits, 0);
    check("rst_out_last", out_last, 0);
    check("rst_blk_idx", out_blk_idx, 0);
  endtask

  // Downstream ready: optional forced stall at the start of an OUT phase, else random or high.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (rand_ready) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  bit    prev_valid = 0;
  bit    snap_v = 0;
  desc_t snap;

  // Monitor: rise timing, stall stability and descriptor comparison against the queue.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 0;
      snap_v = 0;
    end else begin
      if (out_valid && !prev_valid && exp_q.size() > 0) check("out_valid_rise_cycle", cyc, exp_q[0].rise);
      if (out_valid) check("in_ready_low_in_out", in_ready, 0);
      if (snap_v) begin
        check("stall_valid", out_valid, 1);
        check("stall_s1", int'(out_s1), snap.s1);
        check("stall_s4", int'(out_s4), snap.s4);
        check("stall_bits", out_bits, snap.bits);
        check("stall_idx", out_blk_idx, snap.idx);
      end
      if (out_valid && out_ready) begin
        snap_v = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_descriptor", 1, 0);
        end else begin
          desc_t d;
          d = exp_q.pop_front();
          check("s1", int'(out_s1), d.s1);
          check("s2", int'(out_s2), d.s2);
          check("s3", int'(out_s3), d.s3);
          check("s4", int'(out_s4), d.s4);
          check("bits", out_bits, d.bits);
          check("tc", out_tc, d.tc);
          check("nvalid", out_nvalid, d.nvalid);
          check("last", out_last, d.last);
          check("blk_idx", out_blk_idx, d.idx);
        end
      end else if (out_valid) begin
        snap_v = 1;
        snap.s1 = int'(out_s1);
        snap.s4 = int'(out_s4);
        snap.bits = int'(out_bits);
        snap.idx = int'(out_blk_idx);
      end else begin
        snap_v = 0;
      end
      prev_valid = out_valid;
    end
  end

  initial begin
    int sm_blk[4];
    int tc_blk[4];
    int waited;
    sm_blk = '{5, -3, 7, 1};
    tc_blk = '{-4, 3, -1, 2};
    rst = 1'b1;
    in_valid = 1'b0;
    in_sample = '0;
    ecgidx = 2'd0;
    flush = 1'b0;
    m_idx = 0;
    cur_mode = 0;
    @(posedge clk);
    #1;
    do_reset();

    // SM then TC block back to back; mode change mid-block must be ignored.
    blk_start_q.delete();
    for (int i = 0; i < 4; i++) send(sm_blk[i], 0, 1'b0);
    for (int i = 0; i < 4; i++) send(tc_blk[i], (i == 0) ? 3 : 0, 1'b0);
    check("min_block_period", blk_start_q[1] - blk_start_q[0], 6);
    check("sm_model_bits", exp_q.size() > 0 ? exp_q[0].bits : 3, 3);
    idle(4, 1'b0);

    // Partial flush, ignored idle flush, flush with a same-cycle sample, flush on the 4th sample.
    send(9, 0, 1'b0);
    send(-2, 0, 1'b0);
    idle(1, 1'b1);
    idle(6, 1'b1);
    send(100, 1, 1'b0);
    send(-60, 1, 1'b0);
    send(-511, 1, 1'b1);
    idle(6, 1'b0);
    for (int i = 0; i < 4; i++) send(i * 37 - 70, 3, i == 3);
    idle(6, 1'b0);

    // Frame wrap over 17 full blocks.
    for (int b = 0; b < 17; b++) begin
      int e;
      e = int'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) send(int'($urandom_range(0, 1023)) - 512, e, 1'b0);
    end
    idle(6, 1'b0);

    // Backpressure: five stalled OUT cycles stretch the block period to 11.
    blk_start_q.delete();
    stall_left = 5;
    for (int i = 0; i < 8; i++) send(i - 3, 0, 1'b0);
    check("stalled_block_period", blk_start_q[1] - blk_start_q[0], 11);
    idle(8, 1'b0);

    // Reset with three samples of a block already accepted.
    send(200, 0, 1'b0);
    send(-7, 0, 1'b0);
    send(33, 0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) send(i + 1, 3, 1'b0);
    idle(6, 1'b0);

    // Random traffic with random backpressure, flushes and modes.
    rand_ready = 1;
    for (int c = 0; c < 600; c++) begin
      bit acc;
      int s;
      s = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? 511 : -512)
                                       : int'($urandom_range(0, 1023)) - 512;
      drive($urandom_range(0, 3) != 0, s, int'($urandom_range(0, 3)),
            $urandom_range(0, 15) == 0, acc);
    end
    idle(2, 1'b1);
    rand_ready = 0;
    waited = 0;
    while ((exp_q.size() > 0 || out_valid) && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("drain_pending_descriptors", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
